// File: rtl/dpram_pkg.sv
// Shared types and constants for the byte-enabled dual-port RAM with clear-on-reset.
package dpram_pkg;

  // Sequencer states: zero-fill the array, then normal operation.
  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } dpram_state_e;

  // Same-port read-during-write modes.
  localparam int RD_FIRST = 0;  // return the word as it was before the write
  localparam int WR_FIRST = 1;  // return the word as it is after the write

  // Number of byte lanes in a word.
  function automatic int be_width(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/dpram_be_clr_if.sv
// One RAM access port: request from the client, read data and valid strobe back.
interface dpram_port_if
  import dpram_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16
);

  localparam int BE_W = be_width(DATA_W);

  logic              ce;     // access enable
  logic [BE_W-1:0]   we;     // byte write enables, all zero means read
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] write;  // write data
  logic [DATA_W-1:0] read;   // read data
  logic              valid;  // read carries data for an access of this port

  modport master (output ce, we, addr, write, input  read, valid);
  modport slave  (input  ce, we, addr, write, output read, valid);

endinterface

// File: rtl/dpram_be_core.sv
// Raw storage array with two byte-enabled read/write ports. On a same-address,
// same-lane write collision port A wins; a port that only reads always sees
// the word as it was before this cycle's writes.
module dpram_be_core
  import dpram_pkg::*;
#(
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 16,
  parameter int RD_MODE = RD_FIRST
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [be_width(DATA_W)-1:0] a_we,
  input  logic [ADDR_W-1:0]          a_addr,
  input  logic [DATA_W-1:0]          a_wdata,
  input  logic                       a_cap,    // capture read data for port A
  output logic [DATA_W-1:0]          a_q,
  input  logic [be_width(DATA_W)-1:0] b_we,
  input  logic [ADDR_W-1:0]          b_addr,
  input  logic [DATA_W-1:0]          b_wdata,
  input  logic                       b_cap,    // capture read data for port B
  output logic [DATA_W-1:0]          b_q
);

  localparam int BE_W  = be_width(DATA_W);
  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [DATA_W-1:0] a_old, b_old;   // contents before this cycle's writes
  logic [DATA_W-1:0] a_new, b_new;   // contents after this cycle's writes
  logic              same_addr;

  assign a_old     = mem[a_addr];
  assign b_old     = mem[b_addr];
  assign same_addr = (a_addr == b_addr);

  // Word each port's address will hold after this edge, with port A priority.
  always_comb begin
    a_new = a_old;
    b_new = b_old;
    for (int i = 0; i < BE_W; i++) begin
      if (a_we[i])
        a_new[i*8 +: 8] = a_wdata[i*8 +: 8];
      else if (same_addr && b_we[i])
        a_new[i*8 +: 8] = b_wdata[i*8 +: 8];

      if (same_addr && a_we[i])
        b_new[i*8 +: 8] = a_wdata[i*8 +: 8];
      else if (b_we[i])
        b_new[i*8 +: 8] = b_wdata[i*8 +: 8];
    end
  end

  // Byte-lane writes; port A is written last so it wins shared lanes.
  // NOTE: the array has no reset so it maps onto block RAM; known contents
  // come from the clear sequencer in the parent instead.
  always_ff @(posedge clk) begin
    for (int i = 0; i < BE_W; i++) begin
      if (b_we[i]) mem[b_addr][i*8 +: 8] <= b_wdata[i*8 +: 8];
      if (a_we[i]) mem[a_addr][i*8 +: 8] <= a_wdata[i*8 +: 8];
    end
  end

  // Read data registers; a write returns old or merged data depending on RD_MODE.
  // NOTE: state updates use non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q <= '0;
      b_q <= '0;
    end else begin
      if (a_cap) a_q <= (RD_MODE == WR_FIRST && |a_we) ? a_new : a_old;
      if (b_cap) b_q <= (RD_MODE == WR_FIRST && |b_we) ? b_new : b_old;
    end
  end

endmodule

// File: rtl/dpram_be_clr.sv
// True dual-port RAM with byte enables, selectable read-during-write mode,
// optional output register and a post-reset zero-fill sequencer that owns
// port A until every word has been cleared.
module dpram_be_clr
  import dpram_pkg::*;
#(
  parameter int ADDR_W         = 12,
  parameter int DATA_W         = 16,
  parameter int RD_MODE        = RD_FIRST,
  parameter int OUT_REG        = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  dpram_port_if.slave  a,
  dpram_port_if.slave  b,
  output logic         init_busy
);

  localparam int BE_W = be_width(DATA_W);
  localparam dpram_state_e RESET_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : RUN;
  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  dpram_state_e      state_q, state_n;
  logic [ADDR_W-1:0] clr_addr_q, clr_addr_n;

  logic              a_acc, b_acc;
  logic [BE_W-1:0]   core_a_we, core_b_we;
  logic [ADDR_W-1:0] core_a_addr;
  logic [DATA_W-1:0] core_a_wdata;
  logic [DATA_W-1:0] core_a_q, core_b_q;
  logic              a_v1, b_v1;

  // Sequencer state and clear address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RESET_STATE;
      clr_addr_q <= '0;
    end else begin
      state_q    <= state_n;
      clr_addr_q <= clr_addr_n;
    end
  end

  // Walk the clear address once through the array, then stay in RUN.
  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_n    = state_q;
    clr_addr_n = clr_addr_q;
    if (state_q == CLEAR) begin
      clr_addr_n = clr_addr_q + ADDR_ONE;
      if (clr_addr_q == '1) state_n = RUN;
    end
  end

  assign init_busy = (state_q == CLEAR);

  // Client accesses only count once the clear has finished.
  assign a_acc = (state_q == RUN) && a.ce;
  assign b_acc = (state_q == RUN) && b.ce;

  // The sequencer borrows port A to write zeros to every lane.
  assign core_a_we    = init_busy ? '1         : (a_acc ? a.we : '0);
  assign core_a_addr  = init_busy ? clr_addr_q : a.addr;
  assign core_a_wdata = init_busy ? '0         : a.write;
  assign core_b_we    = b_acc ? b.we : '0;

  dpram_be_core #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .RD_MODE (RD_MODE)
  ) u_core (
    .clk     (clk),
    .rst_n   (rst_n),
    .a_we    (core_a_we),
    .a_addr  (core_a_addr),
    .a_wdata (core_a_wdata),
    .a_cap   (a_acc),
    .a_q     (core_a_q),
    .b_we    (core_b_we),
    .b_addr  (b.addr),
    .b_wdata (b.write),
    .b_cap   (b_acc),
    .b_q     (core_b_q)
  );

  // First valid stage lines up with the core read register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_v1 <= 1'b0;
      b_v1 <= 1'b0;
    end else begin
      a_v1 <= a_acc;
      b_v1 <= b_acc;
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic              a_v2, b_v2;
    logic [DATA_W-1:0] a_d2, b_d2;

    // Extra output stage; data only advances with a valid so it holds otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        a_v2 <= 1'b0;
        b_v2 <= 1'b0;
        a_d2 <= '0;
        b_d2 <= '0;
      end else begin
        a_v2 <= a_v1;
        b_v2 <= b_v1;
        if (a_v1) a_d2 <= core_a_q;
        if (b_v1) b_d2 <= core_b_q;
      end
    end

    assign a.valid = a_v2;
    assign b.valid = b_v2;
    assign a.read  = a_d2;
    assign b.read  = b_d2;
  end else begin : g_no_out_reg
    assign a.valid = a_v1;
    assign b.valid = b_v1;
    assign a.read  = core_a_q;
    assign b.read  = core_b_q;
  end

endmodule

// File: tb/tb_dpram_be_clr.sv
// Scoreboard bench: two instances (read-first / no output register and
// write-first / output register) see identical stimulus; expected words and
// issue cycles are queued per port and a monitor checks every valid strobe.
module tb_dpram_be_clr;
  import dpram_pkg::*;

  localparam int AW = 4;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy0, busy1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  typedef struct {
    logic [15:0] data;
    bit          care;
    int          cyc;
  } exp_t;

  // 0: dut0 port A, 1: dut0 port B, 2: dut1 port A, 3: dut1 port B
  exp_t exp_q [4][$];

  dpram_port_if #(.ADDR_W(AW), .DATA_W(DW)) a0 ();
  dpram_port_if #(.ADDR_W(AW), .DATA_W(DW)) b0 ();
  dpram_port_if #(.ADDR_W(AW), .DATA_W(DW)) a1 ();
  dpram_port_if #(.ADDR_W(AW), .DATA_W(DW)) b1 ();

  dpram_be_clr #(.ADDR_W(AW), .DATA_W(DW), .RD_MODE(RD_FIRST), .OUT_REG(0),
                 .CLEAR_ON_RESET(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .a(a0.slave), .b(b0.slave), .init_busy(busy0));

  dpram_be_clr #(.ADDR_W(AW), .DATA_W(DW), .RD_MODE(WR_FIRST), .OUT_REG(1),
                 .CLEAR_ON_RESET(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .a(a1.slave), .b(b1.slave), .init_busy(busy1));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Compare one port's output against the head of its expectation queue.
  task automatic mon(input int id, input logic v, input logic [15:0] d);
    int   lat;
    exp_t e;
    lat = (id < 2) ? 1 : 2;
    if (v) begin
      if (exp_q[id].size() == 0) begin
        check($sformatf("unexpected_valid[%0d]@%0d", id, cyc), 1, 0);
      end else begin
        e = exp_q[id].pop_front();
        check($sformatf("latency[%0d]", id), cyc, e.cyc + lat);
        if (e.care) check($sformatf("data[%0d]@%0d", id, cyc), {16'h0, d}, {16'h0, e.data});
      end
    end else if (exp_q[id].size() != 0 && exp_q[id][0].cyc + lat < cyc) begin
      e = exp_q[id].pop_front();
      check($sformatf("missing_valid[%0d]", id), 0, 1);
    end
  endtask

  always @(negedge clk) begin
    mon(0, a0.valid, a0.read);
    mon(1, b0.valid, b0.read);
    mon(2, a1.valid, a1.read);
    mon(3, b1.valid, b1.read);
  end

  task automatic drive_a(input logic [1:0] we, input logic [3:0] addr, input logic [15:0] wd);
    a0.ce = 1'b1; a0.we = we; a0.addr = addr; a0.write = wd;
    a1.ce = 1'b1; a1.we = we; a1.addr = addr; a1.write = wd;
  endtask

  // e0: expected return on the read-first instance, e1 on the write-first one.
  task automatic issue_a(input logic [1:0] we, input logic [3:0] addr, input logic [15:0] wd,
                         input logic [15:0] e0, input logic [15:0] e1, input bit care1);
    drive_a(we, addr, wd);
    exp_q[0].push_back('{data: e0, care: 1'b1, cyc: cyc});
    exp_q[2].push_back('{data: e1, care: care1, cyc: cyc});
  endtask

  task automatic issue_b(input logic [1:0] we, input logic [3:0] addr, input logic [15:0] wd,
                         input logic [15:0] e0, input logic [15:0] e1, input bit care1);
    b0.ce = 1'b1; b0.we = we; b0.addr = addr; b0.write = wd;
    b1.ce = 1'b1; b1.we = we; b1.addr = addr; b1.write = wd;
    exp_q[1].push_back('{data: e0, care: 1'b1, cyc: cyc});
    exp_q[3].push_back('{data: e1, care: care1, cyc: cyc});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    a0.ce = 1'b0; a1.ce = 1'b0; b0.ce = 1'b0; b1.ce = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  // Count edges from reset release until init_busy drops (bounded).
  task automatic count_busy(input string name);
    int edges;
    edges = 0;
    while (busy0 && edges < 100) begin
      @(posedge clk);
      #1;
      edges++;
    end
    check(name, edges, 16);
    check({name, "_dut1_low"}, {31'h0, busy1}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    a0.ce = 0; a0.we = '0; a0.addr = '0; a0.write = '0;
    a1.ce = 0; a1.we = '0; a1.addr = '0; a1.write = '0;
    b0.ce = 0; b0.we = '0; b0.addr = '0; b0.write = '0;
    b1.ce = 0; b1.we = '0; b1.addr = '0; b1.write = '0;

    // Reset values.
    #12;
    check("rst_a_read", {16'h0, a0.read}, 0);
    check("rst_b_read", {16'h0, b1.read}, 0);
    check("rst_valid", {28'h0, a0.valid, b0.valid, a1.valid, b1.valid}, 0);
    check("rst_busy", {30'h0, busy0, busy1}, 32'h3);

    // Clean clear: 16 cycles, then every word reads back as zero.
    @(negedge clk); rst_n = 1'b1;
    count_busy("busy_len_first");
    for (int i = 0; i < 16; i++) begin
      issue_a(2'b00, 4'(i), 16'h0, 16'h0000, 16'h0000, 1'b1);
      issue_b(2'b00, 4'(15 - i), 16'h0, 16'h0000, 16'h0000, 1'b1);
      step();
    end
    idle(3);

    // Reset again, interrupt the clear at cycle 7; a write during clear is dropped.
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    repeat (7) @(posedge clk);
    #1;
    drive_a(2'b11, 4'd3, 16'hBEEF);
    @(negedge clk); rst_n = 1'b0;
    #1;
    check("midclear_rst_busy", {30'h0, busy0, busy1}, 32'h3);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    count_busy("busy_len_restart");
    a0.ce = 1'b0; a1.ce = 1'b0;
    issue_a(2'b00, 4'd3, 16'h0, 16'h0000, 16'h0000, 1'b1);
    step();

    // Byte-lane merge on address 5.
    issue_a(2'b11, 4'd5, 16'h1234, 16'h0000, 16'h1234, 1'b1); step();
    issue_a(2'b10, 4'd5, 16'hAB00, 16'h1234, 16'hAB34, 1'b1); step();
    issue_a(2'b00, 4'd5, 16'h0000, 16'hAB34, 16'hAB34, 1'b1); step();

    // Write/write collision on address 9: port A wins shared lanes.
    issue_a(2'b11, 4'd9, 16'h1111, 16'h0000, 16'h1111, 1'b1);
    issue_b(2'b11, 4'd9, 16'h2222, 16'h0000, 16'h0000, 1'b0);
    step();
    issue_a(2'b00, 4'd9, 16'h0000, 16'h1111, 16'h1111, 1'b1); step();
    issue_a(2'b01, 4'd9, 16'h1111, 16'h1111, 16'h0000, 1'b0);
    issue_b(2'b10, 4'd9, 16'h2222, 16'h1111, 16'h0000, 1'b0);
    step();
    issue_a(2'b00, 4'd9, 16'h0000, 16'h2211, 16'h2211, 1'b1);
    issue_b(2'b00, 4'd9, 16'h0000, 16'h2211, 16'h2211, 1'b1);
    step();

    // Read-during-write: writer follows RD_MODE, cross-port reader sees old data.
    issue_a(2'b11, 4'd2, 16'h0F0F, 16'h0000, 16'h0F0F, 1'b1); step();
    issue_a(2'b11, 4'd2, 16'h5555, 16'h0F0F, 16'h5555, 1'b1);
    issue_b(2'b00, 4'd2, 16'h0000, 16'h0F0F, 16'h0F0F, 1'b1);
    step();
    issue_b(2'b00, 4'd2, 16'h0000, 16'h5555, 16'h5555, 1'b1); step();

    // Top address.
    issue_b(2'b11, 4'd15, 16'hFFFF, 16'h0000, 16'hFFFF, 1'b1); step();
    issue_a(2'b00, 4'd15, 16'h0000, 16'hFFFF, 16'hFFFF, 1'b1); step();
    idle(3);

    // Back-to-back reads through the output register.
    issue_a(2'b11, 4'd0, 16'h00A0, 16'h0000, 16'h00A0, 1'b1); step();
    issue_a(2'b11, 4'd1, 16'h00A1, 16'h0000, 16'h00A1, 1'b1); step();
    issue_a(2'b11, 4'd2, 16'h00A2, 16'h5555, 16'h00A2, 1'b1); step();
    idle(3);
    issue_a(2'b00, 4'd0, 16'h0000, 16'h00A0, 16'h00A0, 1'b1); step();
    issue_a(2'b00, 4'd1, 16'h0000, 16'h00A1, 16'h00A1, 1'b1); step();
    issue_a(2'b00, 4'd2, 16'h0000, 16'h00A2, 16'h00A2, 1'b1); step();
    idle(5);

    // Read data holds once nothing is in flight; every expectation consumed.
    check("hold_a0", {16'h0, a0.read}, 32'h00A2);
    check("hold_a1", {16'h0, a1.read}, 32'h00A2);
    for (int i = 0; i < 4; i++)
      check($sformatf("queue_drained[%0d]", i), exp_q[i].size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
